// File: rtl/turbosound_n_if.sv
// rtl/turbosound_n_if.sv - PSG bus, chip read-back and audio bundle for turbosound_n
interface turbosound_n_if #(
  parameter int NCHIPS = 2
) ();
  logic                  bdir;
  logic                  bc1;
  logic [7:0]            din;
  logic [8*NCHIPS-1:0]   dout_chips;
  logic [NCHIPS-1:0]     oe_n_chips;
  logic [8*NCHIPS-1:0]   audio_chips;
  logic [NCHIPS-1:0]     chip_sel;
  logic [7:0]            dout;
  logic                  oe_n;
  logic [9:0]            audio_l;
  logic [9:0]            audio_r;
  logic                  sample_stb;

  modport master (
    output bdir, bc1, din, dout_chips, oe_n_chips, audio_chips,
    input  chip_sel, dout, oe_n, audio_l, audio_r, sample_stb
  );

  modport slave (
    input  bdir, bc1, din, dout_chips, oe_n_chips, audio_chips,
    output chip_sel, dout, oe_n, audio_l, audio_r, sample_stb
  );
endinterface

// File: rtl/turbosound_n.sv
// rtl/turbosound_n.sv - multi-PSG select/read-back arbiter with panned stereo mixer
module turbosound_n #(
  parameter int NCHIPS = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  turbosound_n_if.slave  bus
);

  localparam logic [1:0] LAST_IDX = 2'(NCHIPS - 1);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  logic [1:0]        sel_q, sel_d;
  logic [NCHIPS-1:0] chip_sel_q, chip_sel_d;
  logic [NCHIPS-1:0] len_q, len_d;
  logic [NCHIPS-1:0] ren_q, ren_d;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [9:0]        acc_l_q, acc_l_d;
  logic [9:0]        acc_r_q, acc_r_d;
  logic [9:0]        audio_l_q, audio_l_d;
  logic [9:0]        audio_r_q, audio_r_d;
  logic              stb_q, stb_d;

  logic              sel_cmd;
  logic [1:0]        tgt;
  logic              tgt_ok;
  logic [7:0]        dout_mux;
  logic              oe_n_mux;
  logic [7:0]        cur_audio;
  logic              cur_len;
  logic              cur_ren;

  // Select byte: 1 L R 1 1 1 S1 S0, chip index counts down from 3 so 0xFF/0xFE keep the two-chip mapping
  assign sel_cmd = bus.bdir & bus.bc1 & bus.din[7] & (bus.din[4:2] == 3'b111);
  assign tgt     = ~bus.din[1:0];
  assign tgt_ok  = (int'(tgt) < NCHIPS);

  // Next select/enable state; commands aimed at absent chips leave everything untouched
  always_comb begin
    sel_d      = sel_q;
    chip_sel_d = chip_sel_q;
    len_d      = len_q;
    ren_d      = ren_q;
    if (sel_cmd && tgt_ok) begin
      sel_d      = tgt;
      chip_sel_d = '0;
      for (int k = 0; k < NCHIPS; k++) begin
        if (tgt == 2'(k)) begin
          chip_sel_d[k] = 1'b1;
          len_d[k]      = bus.din[6];
          ren_d[k]      = bus.din[5];
        end
      end
    end
  end

  // Select and per-chip enable registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q      <= 2'd0;
      chip_sel_q <= NCHIPS'(1);
      len_q      <= '1;
      ren_q      <= '1;
    end else begin
      sel_q      <= sel_d;
      chip_sel_q <= chip_sel_d;
      len_q      <= len_d;
      ren_q      <= ren_d;
    end
  end

  // Read-back mux follows the registered selection
  always_comb begin
    dout_mux = bus.dout_chips[7:0];
    oe_n_mux = bus.oe_n_chips[0];
    for (int k = 0; k < NCHIPS; k++) begin
      if (sel_q == 2'(k)) begin
        dout_mux = bus.dout_chips[8*k +: 8];
        oe_n_mux = bus.oe_n_chips[k];
      end
    end
  end

  // Audio sample and enables of the chip the mixer visits this cycle (pre-write enable values)
  always_comb begin
    cur_audio = bus.audio_chips[7:0];
    cur_len   = len_q[0];
    cur_ren   = ren_q[0];
    for (int k = 0; k < NCHIPS; k++) begin
      if (idx_q == 2'(k)) begin
        cur_audio = bus.audio_chips[8*k +: 8];
        cur_len   = len_q[k];
        cur_ren   = ren_q[k];
      end
    end
  end

  // Mixer next state: one chip summed per ACC cycle, then one OUT cycle publishes the frame
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    stb_d     = 1'b0;
    case (state_q)
      ST_ACC: begin
        acc_l_d = acc_l_q + (cur_len ? {2'b00, cur_audio} : 10'd0);
        acc_r_d = acc_r_q + (cur_ren ? {2'b00, cur_audio} : 10'd0);
        if (idx_q == LAST_IDX) begin
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_OUT: begin
        audio_l_d = acc_l_q;
        audio_r_d = acc_r_q;
        stb_d     = 1'b1;
        acc_l_d   = 10'd0;
        acc_r_d   = 10'd0;
        idx_d     = 2'd0;
        state_d   = ST_ACC;
      end
    endcase
  end

  // Mixer state, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_ACC;
      idx_q     <= 2'd0;
      acc_l_q   <= 10'd0;
      acc_r_q   <= 10'd0;
      audio_l_q <= 10'd0;
      audio_r_q <= 10'd0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      stb_q     <= stb_d;
    end
  end

  assign bus.chip_sel   = chip_sel_q;
  assign bus.dout       = dout_mux;
  assign bus.oe_n       = oe_n_mux;
  assign bus.audio_l    = audio_l_q;
  assign bus.audio_r    = audio_r_q;
  assign bus.sample_stb = stb_q;

endmodule

// File: tb/tb_turbosound_n.sv
// tb/tb_turbosound_n.sv - directed self-checking bench for turbosound_n (2-chip and 4-chip builds)
module tb_turbosound_n;

  logic clk = 1'b0;
  logic rst2_n = 1'b0;
  logic rst4_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  turbosound_n_if #(.NCHIPS(2)) b2 ();
  turbosound_n_if #(.NCHIPS(4)) b4 ();

  turbosound_n #(.NCHIPS(2)) dut2 (.clk(clk), .reset_n(rst2_n), .bus(b2.slave));
  turbosound_n #(.NCHIPS(4)) dut4 (.clk(clk), .reset_n(rst4_n), .bus(b4.slave));

  typedef struct {
    logic       bdir;
    logic       bc1;
    logic [7:0] din;
    logic [1:0] exp_sel;
    logic [7:0] exp_dout;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_stb2();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b2.sample_stb) begin
        ok = 1'b1;
        break;
      end
    end
    check("stb2_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_stb4();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b4.sample_stb) begin
        ok = 1'b1;
        break;
      end
    end
    check("stb4_seen", 32'(ok), 32'd1);
  endtask

  task automatic write2(input logic [7:0] b);
    b2.bdir = 1'b1;
    b2.bc1  = 1'b1;
    b2.din  = b;
    @(negedge clk);
    b2.bdir = 1'b0;
    b2.bc1  = 1'b0;
  endtask

  task automatic write4(input logic [7:0] b);
    b4.bdir = 1'b1;
    b4.bc1  = 1'b1;
    b4.din  = b;
    @(negedge clk);
    b4.bdir = 1'b0;
    b4.bc1  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hFE, 2'b10, 8'hB2, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'hFF, 2'b01, 8'hA1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hFE, 2'b10, 8'hB2, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'hFD, 2'b10, 8'hB2, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'hFC, 2'b10, 8'hB2, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'hFF, 2'b10, 8'hB2, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 2'b10, 8'hB2, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h7F, 2'b10, 8'hB2, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'hEF, 2'b10, 8'hB2, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 2'b01, 8'hA1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 2'b01, 8'hA1, 1'b0};

    b2.bdir = 1'b0; b2.bc1 = 1'b0; b2.din = 8'h00;
    b2.dout_chips = {8'hB2, 8'hA1};
    b2.oe_n_chips = 2'b10;
    b2.audio_chips = {8'h05, 8'h10};
    b4.bdir = 1'b0; b4.bc1 = 1'b0; b4.din = 8'h00;
    b4.dout_chips = {8'h44, 8'h33, 8'h22, 8'h11};
    b4.oe_n_chips = 4'b0000;
    b4.audio_chips = {4{8'hFF}};

    // 2-chip: reset state and first-strobe latency
    repeat (3) @(negedge clk);
    check("rst_chip_sel", 32'(b2.chip_sel), 32'h1);
    check("rst_audio_l", 32'(b2.audio_l), 32'h0);
    check("rst_audio_r", 32'(b2.audio_r), 32'h0);
    check("rst_stb", 32'(b2.sample_stb), 32'h0);
    check("rst_dout", 32'(b2.dout), 32'hA1);
    rst2_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("first_stb_timing", 32'(b2.sample_stb), (c == 3) ? 32'd1 : 32'd0);
    end
    check("first_audio_l", 32'(b2.audio_l), 32'h15);
    check("first_audio_r", 32'(b2.audio_r), 32'h15);

    // 2-chip: select command table
    for (int i = 0; i < 11; i++) begin
      b2.bdir = vecs[i].bdir;
      b2.bc1  = vecs[i].bc1;
      b2.din  = vecs[i].din;
      @(negedge clk);
      check($sformatf("vec%0d_chip_sel", i), 32'(b2.chip_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_dout", i), 32'(b2.dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_oe_n", i), 32'(b2.oe_n), 32'(vecs[i].exp_oe));
    end
    b2.bdir = 1'b0;
    b2.bc1  = 1'b0;

    // 2-chip: panning, chip0 right only, chip1 left only
    b2.audio_chips = {8'h20, 8'h40};
    write2(8'hBF);
    write2(8'hDE);
    wait_stb2();
    wait_stb2();
    check("pan_audio_l", 32'(b2.audio_l), 32'h20);
    check("pan_audio_r", 32'(b2.audio_r), 32'h40);

    // 2-chip: reset one cycle into a frame discards partial sums and restores enables
    wait_stb2();
    @(negedge clk);
    rst2_n = 1'b0;
    b2.audio_chips = {8'h04, 8'h03};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_no_stb", 32'(b2.sample_stb), 32'd0);
    end
    check("midrst_audio_l", 32'(b2.audio_l), 32'h0);
    rst2_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("midrst_stb_timing", 32'(b2.sample_stb), (c == 3) ? 32'd1 : 32'd0);
    end
    check("midrst_audio_l_after", 32'(b2.audio_l), 32'h07);
    check("midrst_audio_r_after", 32'(b2.audio_r), 32'h07);

    // 2-chip: disable chip0 on the very edge it is summed; that frame still includes it
    write2(8'h9F);
    wait_stb2();
    check("race_audio_l", 32'(b2.audio_l), 32'h07);
    check("race_audio_r", 32'(b2.audio_r), 32'h07);
    wait_stb2();
    check("race_next_l", 32'(b2.audio_l), 32'h04);
    check("race_next_r", 32'(b2.audio_r), 32'h04);

    // 4-chip: full-scale mix, period and hold
    check("rst4_chip_sel", 32'(b4.chip_sel), 32'h1);
    rst4_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check("stb4_period", 32'(b4.sample_stb), (c % 5 == 0) ? 32'd1 : 32'd0);
      if (c >= 5) begin
        check("mix4_audio_l", 32'(b4.audio_l), 32'd1020);
        check("mix4_audio_r", 32'(b4.audio_r), 32'd1020);
      end
    end

    // 4-chip: chips 3 and 2 reachable, chip 3 muted
    write4(8'hFC);
    check("sel4_chip3", 32'(b4.chip_sel), 32'h8);
    check("sel4_dout3", 32'(b4.dout), 32'h44);
    write4(8'h9C);
    wait_stb4();
    wait_stb4();
    check("mute3_audio_l", 32'(b4.audio_l), 32'd765);
    check("mute3_audio_r", 32'(b4.audio_r), 32'd765);
    write4(8'hFD);
    check("sel4_chip2", 32'(b4.chip_sel), 32'h4);
    check("sel4_dout2", 32'(b4.dout), 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbosound_n.md
# turbosound_n

Parametrised multi-PSG front end for the Spectrum core: arbitrates CPU register access across NCHIPS external YM2149 instances and mixes their audio into a panned stereo pair. Successor to the fixed two-chip TurboSound selector; adds up to four chips, per-chip left/right enables and a registered, time-multiplexed stereo mixer with a sample strobe. Sits between the PSG bus decoder and the YM2149 instances and audio DAC path.

## Interface
- NCHIPS, 2, number of attached PSGs, legal 1..4
- clk  in  1  system clock; also clocks the mixer
- reset_n  in  1  synchronous, active-low reset
- bdir  in  1  PSG bus direction (decoded)
- bc1  in  1  PSG bus control 1 (decoded)
- din  in  8  CPU data to PSGs
- dout_chips  in  8*NCHIPS  read data from chip k at bits [8k+7:8k]
- oe_n_chips  in  NCHIPS  read-enable (active low) from chip k
- audio_chips  in  8*NCHIPS  unsigned audio from chip k at bits [8k+7:8k]
- chip_sel  out  NCHIPS  one-hot, drives A8 of each chip
- dout  out  8  read data of selected chip
- oe_n  out  1  oe_n of selected chip
- audio_l  out  10  unsigned left mix
- audio_r  out  10  unsigned right mix
- sample_stb  out  1  one-cycle pulse, new audio_l/audio_r valid

## Operation
- Select register sel (2 bits), per-chip enable registers len[k], ren[k].
- Select command: any clk edge with bdir=1, bc1=1, din[7]=1, din[4:2]=3'b111. Fields: L=din[6], R=din[5], S=din[1:0]; target index t = 3 - S.
- If t < NCHIPS: sel <= t, len[t] <= L, ren[t] <= R. If t >= NCHIPS: command ignored entirely (no register changes).
- Bytes not matching the pattern are ordinary PSG address latches; block does not alter them.
- 0xFF selects chip 0 with both channels on; 0xFE selects chip 1: backward compatible with the two-chip scheme.
- chip_sel = one-hot of sel, registered. dout/oe_n: combinational mux of dout_chips/oe_n_chips indexed by registered sel.
- Mixer FSM, states ACC and OUT. Counter idx 0..NCHIPS-1.
  - ACC: acc_l += len[idx] ? audio_chips[idx] : 0; acc_r likewise with ren[idx]; if idx = NCHIPS-1 go OUT, else idx+1.
  - OUT: audio_l <= acc_l, audio_r <= acc_r, sample_stb <= 1, accumulators and idx cleared, go ACC.
- Accumulator width 10 bits; max 4*255 = 1020, no overflow, no saturation.
- Enable bits sampled at the cycle idx visits the chip; changes mid-frame affect only not-yet-summed chips.

## Timing
- Reset values: sel=0, chip_sel=1 (chip 0), len=ren=all 1, acc=0, idx=0, state ACC, audio_l=audio_r=0, sample_stb=0; dout/oe_n follow chip 0 inputs.
- Select command: sel, chip_sel, enables valid the edge after the command cycle (1-cycle latency). Held bdir/bc1 repeats the write idempotently.
- Mixer period NCHIPS+1 cycles; sample_stb high exactly one cycle per period, coincident with updated audio outputs; outputs hold between strobes.
- First sample_stb after reset release: NCHIPS+1 cycles after the first edge with reset_n=1.
- Audio inputs sampled in ACC cycles only; audio from chip k sampled at cycle k of the frame.
- Reset mid-frame: partial sums discarded, all state to reset values on that edge; no strobe during reset.
- Simultaneous select write and mixer ACC of the same chip: mixer uses the pre-write enable value.

## Test plan
- Reset, NCHIPS=2: chip_sel=2'b01, audio_l=audio_r=0, sample_stb=0; first strobe 3 cycles after release.
- Write 0xFE then 0xFF (NCHIPS=2): chip_sel 2'b10 then 2'b01, each one cycle after write; dout follows dout_chips byte of selected chip.
- NCHIPS=2, write 0xFD (t=2): no change to chip_sel or enables; then 0xFC with NCHIPS=4 -> chip_sel=4'b1000.
- NCHIPS=4, all audio 0xFF, all enabled: audio_l=audio_r=1020 at every strobe, strobe period 5 cycles.
- NCHIPS=2, audio0=0x40, audio1=0x20, write 0xBF (chip0 R only) then 0xDE (chip1 L only): next full frame audio_l=0x20, audio_r=0x40.
- Assert reset_n=0 in cycle 1 of a frame with nonzero accumulators: no strobe, next sample after release reflects only post-reset inputs.
